// File: rtl/load_return_unit_pkg.sv
// Shared opcodes, load funct3 codes, tracker state encoding and the
// alignment rule used by both the issue check and the formatter.
package load_return_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned OFF_W = 2;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  localparam logic [F3_W-1:0] FUNCT3_LB  = 3'b000;
  localparam logic [F3_W-1:0] FUNCT3_LH  = 3'b001;
  localparam logic [F3_W-1:0] FUNCT3_LW  = 3'b010;
  localparam logic [F3_W-1:0] FUNCT3_LBU = 3'b100;
  localparam logic [F3_W-1:0] FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Halfwords need an even offset, words need offset zero.
  function automatic logic is_misaligned(input logic [F3_W-1:0] funct3,
                                         input logic [OFF_W-1:0] off);
    case (funct3)
      FUNCT3_LH, FUNCT3_LHU: return off[0];
      FUNCT3_LW:             return off != 2'b00;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load alignment and extension; a misaligned or undefined
// access yields zero. Shared with the forwarding path.
module load_formatter
  import load_return_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]  raw_i,
  input  logic [F3_W-1:0]  funct3_i,
  input  logic [OFF_W-1:0] off_i,
  output logic [XLEN-1:0]  data_o_c,
  output logic             misaligned_o_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v         = 8'(raw_i >> {off_i, 3'b000});
    half_v         = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    misaligned_o_c = is_misaligned(funct3_i, off_i);
    data_o_c       = '0;
    if (!misaligned_o_c) begin
      case (funct3_i)
        FUNCT3_LB:  data_o_c = {{(XLEN-8){byte_v[7]}}, byte_v};
        FUNCT3_LBU: data_o_c = {{(XLEN-8){1'b0}}, byte_v};
        FUNCT3_LH:  data_o_c = {{(XLEN-16){half_v[15]}}, half_v};
        FUNCT3_LHU: data_o_c = {{(XLEN-16){1'b0}}, half_v};
        FUNCT3_LW:  data_o_c = raw_i;
        default:    data_o_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/load_return_unit.sv
// Single-outstanding load tracker: captures a load issued from X, formats the
// dcache response and hands it to writeback over a valid/ack handshake.
module load_return_unit
  import load_return_unit_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x_valid,
  input  logic [31:0]      x_inst,
  input  logic [XLEN-1:0]  x_addr,
  input  logic             pipe_stall_in,
  input  logic             dcache_resp_valid,
  input  logic [XLEN-1:0]  dcache_resp_data,
  input  logic             wb_ack,
  output logic             stall_out,
  output logic             load_valid,
  output logic [REG_W-1:0] load_rd,
  output logic [XLEN-1:0]  load_data,
  output logic             load_busy,
  output logic             err_misaligned,
  output logic             err_timeout
);

  state_e             state_q, state_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic [F3_W-1:0]    funct3_q, funct3_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic               err_mis_q, err_mis_d;
  logic               err_to_q, err_to_d;

  logic [OPC_W-1:0]   opc;
  logic [REG_W-1:0]   rs1, rs2, x_rd;
  logic [F3_W-1:0]    x_f3;
  logic               reads_rs2, is_mem, load_use, structural, stall_c, issue;
  logic [XLEN-1:0]    fmt_data;
  logic               unused_fmt_mis;
  logic               unused_bits;

  assign opc  = x_inst[6:0];
  assign x_rd = x_inst[11:7];
  assign x_f3 = x_inst[14:12];
  assign rs1  = x_inst[19:15];
  assign rs2  = x_inst[24:20];
  assign unused_bits = ^{x_inst[31:25], x_addr[XLEN-1:OFF_W]};

  // Hazards: true dependence on the tracked rd, or a second memory op while busy.
  assign reads_rs2  = (opc == OPC_OP) | (opc == OPC_BRANCH) | (opc == OPC_STORE);
  assign is_mem     = (opc == OPC_LOAD) | (opc == OPC_STORE);
  assign load_use   = (state_q != ST_IDLE) & x_valid & (rd_q != '0) &
                      ((rs1 == rd_q) | (reads_rs2 & (rs2 == rd_q)));
  assign structural = x_valid & is_mem &
                      ((state_q == ST_WAIT) | ((state_q == ST_READY) & !wb_ack));
  assign stall_c    = load_use | structural;
  assign issue      = x_valid & (opc == OPC_LOAD) & !pipe_stall_in & !stall_c;

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .raw_i          (dcache_resp_data),
    .funct3_i       (funct3_q),
    .off_i          (off_q),
    .data_o_c       (fmt_data),
    .misaligned_o_c (unused_fmt_mis)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      err_mis_q <= err_mis_d;
      err_to_q  <= err_to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    err_mis_d = issue & is_misaligned(x_f3, x_addr[OFF_W-1:0]);
    err_to_d  = err_to_q;

    unique case (state_q)
      ST_IDLE: begin
        if (issue) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Counter saturates so the sticky timeout flag is raised exactly once.
        if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) err_to_d = 1'b1;
        if (dcache_resp_valid) begin
          state_d = ST_READY;
          data_d  = fmt_data;
        end
      end
      ST_READY: begin
        if (wb_ack) state_d = issue ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      rd_d     = x_rd;
      funct3_d = x_f3;
      off_d    = x_addr[OFF_W-1:0];
      cnt_d    = '0;
    end
  end

  assign stall_out      = stall_c;
  assign load_valid     = (state_q == ST_READY);
  assign load_busy      = (state_q != ST_IDLE);
  assign load_rd        = rd_q;
  assign load_data      = data_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_load_return_unit.sv
// Scoreboard bench for load_return_unit: expected results are queued when a
// response is driven and compared when writeback sees load_valid.
module tb_load_return_unit;

  localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010,
                         F_LBU = 3'b100, F_LHU = 3'b101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        x_valid;
  logic [31:0] x_inst;
  logic [31:0] x_addr;
  logic        pipe_stall_in;
  logic        dcache_resp_valid;
  logic [31:0] dcache_resp_data;
  logic        wb_ack;
  logic        stall_out;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        load_busy;
  logic        err_misaligned;
  logic        err_timeout;

  load_return_unit dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .x_valid           (x_valid),
    .x_inst            (x_inst),
    .x_addr            (x_addr),
    .pipe_stall_in     (pipe_stall_in),
    .dcache_resp_valid (dcache_resp_valid),
    .dcache_resp_data  (dcache_resp_data),
    .wb_ack            (wb_ack),
    .stall_out         (stall_out),
    .load_valid        (load_valid),
    .load_rd           (load_rd),
    .load_data         (load_data),
    .load_busy         (load_busy),
    .err_misaligned    (err_misaligned),
    .err_timeout       (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int          checks   = 0;
  int          failures = 0;
  logic [4:0]  pend_rd;
  logic [2:0]  pend_f3;
  logic [1:0]  pend_off;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic mis_model(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == F_LW) return off != 2'd0;
    if (f3 == F_LH || f3 == F_LHU) return off[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] fmt_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    if (mis_model(f3, off)) return 32'd0;
    case (f3)
      F_LB:    return {{24{b[7]}}, b};
      F_LBU:   return {24'd0, b};
      F_LH:    return {{16{h[15]}}, h};
      F_LHU:   return {16'd0, h};
      F_LW:    return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk_load(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [2:0] f3);
    return {12'h000, rs1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic issue_load(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [2:0] f3, input logic [31:0] addr);
    x_valid = 1'b1;
    x_inst  = mk_load(rd, rs1, f3);
    x_addr  = addr;
    #1;
    check({tag, "_issue_stall"}, 32'(stall_out), 32'd0);
    tick();
    x_valid  = 1'b0;
    x_inst   = 32'd0;
    pend_rd  = rd;
    pend_f3  = f3;
    pend_off = addr[1:0];
    check({tag, "_busy"}, 32'(load_busy), 32'd1);
    check({tag, "_mis"}, 32'(err_misaligned), 32'(mis_model(f3, addr[1:0])));
  endtask

  task automatic respond(input logic [31:0] w);
    dcache_resp_valid = 1'b1;
    dcache_resp_data  = w;
    sb.push_back('{pend_rd, fmt_model(pend_f3, pend_off, w)});
    tick();
    dcache_resp_valid = 1'b0;
    dcache_resp_data  = 32'd0;
  endtask

  task automatic expect_result(input string tag);
    check({tag, "_valid"}, 32'(load_valid), 32'd1);
    check({tag, "_sb_level"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      last_exp = sb.pop_front();
      check({tag, "_rd"}, 32'(load_rd), 32'(last_exp.rd));
      check({tag, "_data"}, load_data, last_exp.data);
    end
  endtask

  task automatic ack(input string tag);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(load_valid), 32'd0);
    check({tag, "_ack_busy"}, 32'(load_busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall_out), 32'd0);
    check({tag, "_valid"}, 32'(load_valid), 32'd0);
    check({tag, "_rd"}, 32'(load_rd), 32'd0);
    check({tag, "_data"}, load_data, 32'd0);
    check({tag, "_busy"}, 32'(load_busy), 32'd0);
    check({tag, "_mis"}, 32'(err_misaligned), 32'd0);
    check({tag, "_tmo"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; x_valid = 1'b0; x_inst = 32'd0; x_addr = 32'd0;
    pipe_stall_in = 1'b0; dcache_resp_valid = 1'b0; dcache_resp_data = 32'd0;
    wb_ack = 1'b0;
    pend_rd = '0; pend_f3 = '0; pend_off = '0;
    repeat (2) tick();
    check_all_zero("reset");
    reset_n = 1'b1;

    // Stray response / ack / stalled issue while idle are all ignored.
    dcache_resp_valid = 1'b1; dcache_resp_data = 32'hDEAD_BEEF; wb_ack = 1'b1;
    tick();
    dcache_resp_valid = 1'b0; wb_ack = 1'b0;
    check("idle_resp_valid", 32'(load_valid), 32'd0);
    check("idle_resp_busy", 32'(load_busy), 32'd0);
    pipe_stall_in = 1'b1; x_valid = 1'b1; x_inst = mk_load(5'd3, 5'd1, F_LW);
    tick();
    pipe_stall_in = 1'b0; x_valid = 1'b0;
    check("pipe_stall_busy", 32'(load_busy), 32'd0);

    // LB from byte 3 of 0x80FF_1234 sign-extends 0x80.
    issue_load("lb", 5'd3, 5'd1, F_LB, 32'h0000_1003);
    tick();
    check("lb_wait_valid", 32'(load_valid), 32'd0);
    respond(32'h80FF_1234);
    expect_result("lb");
    check("lb_model", last_exp.data, 32'hFFFF_FF80);
    ack("lb");

    // LHU upper halfword, then misaligned LH.
    issue_load("lhu", 5'd4, 5'd1, F_LHU, 32'h0000_2002);
    respond(32'hBEEF_0001);
    expect_result("lhu");
    ack("lhu");
    issue_load("lh_mis", 5'd4, 5'd1, F_LH, 32'h0000_2001);
    tick();
    check("lh_mis_pulse_end", 32'(err_misaligned), 32'd0);
    respond(32'h1234_5678);
    expect_result("lh_mis");
    ack("lh_mis");

    // Hazards while a load to x5 is in WAIT.
    issue_load("dep", 5'd5, 5'd1, F_LW, 32'h0000_0100);
    x_valid = 1'b1;
    x_inst = mk_add(5'd6, 5'd5, 5'd7);   #1; check("use_rs1_stall", 32'(stall_out), 32'd1);
    x_inst = mk_add(5'd6, 5'd7, 5'd5);   #1; check("use_rs2_stall", 32'(stall_out), 32'd1);
    x_inst = mk_add(5'd8, 5'd9, 5'd10);  #1; check("indep_stall", 32'(stall_out), 32'd0);
    x_inst = mk_load(5'd11, 5'd12, F_LW); #1; check("struct_stall", 32'(stall_out), 32'd1);
    tick();
    x_valid = 1'b0; x_inst = 32'd0;
    check("struct_no_issue", 32'(load_valid), 32'd0);
    respond(32'h0BAD_F00D);
    expect_result("dep");

    // Held result stays stable without ack.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 32'(load_valid), 32'd1);
      check("hold_data", load_data, last_exp.data);
    end

    // Back-to-back: new LW accepted in the ack cycle, straight into WAIT.
    wb_ack = 1'b1; x_valid = 1'b1; x_inst = mk_load(5'd9, 5'd2, F_LW); x_addr = 32'h3000;
    #1;
    check("b2b_stall", 32'(stall_out), 32'd0);
    tick();
    wb_ack = 1'b0; x_valid = 1'b0; x_inst = 32'd0;
    pend_rd = 5'd9; pend_f3 = F_LW; pend_off = 2'd0;
    check("b2b_busy", 32'(load_busy), 32'd1);
    check("b2b_valid", 32'(load_valid), 32'd0);
    respond(32'h1234_5678);
    expect_result("b2b");
    ack("b2b");

    // Timeout at 64 cycles, sticky, then a late response still completes.
    issue_load("tmo", 5'd7, 5'd1, F_LW, 32'h0000_2000);
    repeat (63) tick();
    check("tmo_before", 32'(err_timeout), 32'd0);
    tick();
    check("tmo_at", 32'(err_timeout), 32'd1);
    repeat (5) tick();
    check("tmo_sticky_wait", 32'(load_busy), 32'd1);
    respond(32'hCAFE_F00D);
    expect_result("tmo");
    ack("tmo");
    check("tmo_sticky", 32'(err_timeout), 32'd1);

    // Async reset mid-WAIT clears everything immediately.
    issue_load("rst", 5'd12, 5'd1, F_LBU, 32'h0000_0005);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    reset_n = 1'b1;

    // rd=x0 load never causes a load-use stall but still hands off.
    issue_load("x0", 5'd0, 5'd1, F_LW, 32'h0000_0040);
    x_valid = 1'b1; x_inst = mk_add(5'd1, 5'd0, 5'd0);
    #1;
    check("x0_stall", 32'(stall_out), 32'd0);
    x_valid = 1'b0; x_inst = 32'd0;
    respond(32'hAAAA_5555);
    expect_result("x0");
    ack("x0");

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
